dump_capture_fifo: RTL and testbench

//  Reader side of the correlator integrate-and-dump path. Captures the I and Q sums

---
 rtl/gps_corr_pkg.sv | 40 ++++
 rtl/dump_capture_fifo_if.sv | 30 +++
 rtl/dump_capture_fifo_sync_fifo.sv | 65 ++++++
 rtl/dump_capture_fifo.sv | 106 ++++++++++
 tb/tb_dump_capture_fifo.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gps_corr_pkg.sv
// Shared correlator types: signed I/Q sum, the buffered dump entry, and the
// |I|+|Q| magnitude helper used at capture time.
package gps_corr_pkg;

    localparam int SUM_W = 17;
    localparam int SEQ_W = 8;

    typedef logic signed [SUM_W-1:0] corr_sum_t;
    typedef logic        [SUM_W:0]   corr_mag_t;
    typedef logic        [SEQ_W-1:0] corr_seq_t;

    typedef struct packed {
        corr_seq_t seq;
        corr_sum_t i;
        corr_sum_t q;
        corr_mag_t mag;
    } dump_entry_t;

    // One extra bit lets |-2^(SUM_W-1)| and the sum of two maxima fit exactly.
    function automatic corr_mag_t abs_add(input corr_sum_t a, input corr_sum_t b);
        corr_mag_t ext_a;
        corr_mag_t ext_b;
        corr_mag_t mag_a;
        corr_mag_t mag_b;
        ext_a = {a[SUM_W-1], a};
        ext_b = {b[SUM_W-1], b};
        if (a[SUM_W-1]) begin
            mag_a = ~ext_a + {{SUM_W{1'b0}}, 1'b1};
        end else begin
            mag_a = ext_a;
        end
        if (b[SUM_W-1]) begin
            mag_b = ~ext_b + {{SUM_W{1'b0}}, 1'b1};
        end else begin
            mag_b = ext_b;
        end
        return mag_a + mag_b;
    endfunction

endpackage

// File: rtl/dump_capture_fifo_if.sv
// Valid/ready drain stream carrying one tagged dump entry toward the tracking loop.
interface dump_capture_fifo_if #(
    parameter int SUM_W = 17,
    parameter int SEQ_W = 8
);
    logic                    out_valid;
    logic                    out_ready;
    logic        [SEQ_W-1:0] out_seq;
    logic signed [SUM_W-1:0] out_i;
    logic signed [SUM_W-1:0] out_q;
    logic        [SUM_W:0]   out_mag;

    modport master (
        output out_valid,
        output out_seq,
        output out_i,
        output out_q,
        output out_mag,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_seq,
        input  out_i,
        input  out_q,
        input  out_mag,
        output out_ready
    );
endinterface

// File: rtl/dump_capture_fifo_sync_fifo.sv
// Generic single-clock FIFO over any packed type; wrap-bit pointers give level,
// full and empty without a separate counter.
module sync_fifo #(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  T                         din,
    output T                         dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    T               mem_r [DEPTH];
    logic [AW:0]    wr_ptr_r;
    logic [AW:0]    rd_ptr_r;
    logic           do_push_s;
    logic           do_pop_s;

    assign level = wr_ptr_r - rd_ptr_r;
    assign full  = (level == (AW+1)'(DEPTH));
    assign empty = (wr_ptr_r == rd_ptr_r);

    // A pop frees the slot the same cycle, so a full FIFO still takes a push alongside it.
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage write; contents never matter while empty because dout is masked.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

    // Head entry, forced to zero when nothing is held.
    always_comb begin
        dout = '0;
        if (empty) begin
            dout = '0;
        end else begin
            dout = mem_r[rd_ptr_r[AW-1:0]];
        end
    end

endmodule

// File: rtl/dump_capture_fifo.sv
// Captures I/Q sums one cycle after each enabled dump strobe, tags them with a
// sequence number and |I|+|Q|, and buffers them for the valid/ready consumer.
module dump_capture_fifo
    import gps_corr_pkg::*;
#(
    parameter int SUM_W  = gps_corr_pkg::SUM_W,
    parameter int DEPTH  = 8,
    parameter int SEQ_W  = gps_corr_pkg::SEQ_W,
    parameter int DROP_W = 16,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    dump,
    input  logic signed [SUM_W-1:0] sum_i,
    input  logic signed [SUM_W-1:0] sum_q,
    dump_capture_fifo_if.master     out_if,
    output logic [LVL_W-1:0]        level,
    output logic                    overflow,
    output logic [DROP_W-1:0]       drop_cnt,
    input  logic                    ovf_clr
);
    logic              dump_d_r;
    corr_seq_t         seq_r;
    logic              overflow_r;
    logic [DROP_W-1:0] drop_cnt_r;
    logic              push_s;
    logic              pop_s;
    logic              drop_s;
    logic              full_s;
    logic              empty_s;
    dump_entry_t       entry_s;
    dump_entry_t       head_s;

    // Sums settle one cycle after the strobe, so the push happens on the delayed strobe.
    assign push_s = dump_d_r;
    assign pop_s  = out_if.out_valid & out_if.out_ready;
    assign drop_s = push_s & full_s & ~pop_s;

    assign entry_s.seq = seq_r;
    assign entry_s.i   = sum_i;
    assign entry_s.q   = sum_q;
    assign entry_s.mag = abs_add(sum_i, sum_q);

    sync_fifo #(
        .T     (dump_entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (out_if.out_ready),
        .din   (entry_s),
        .dout  (head_s),
        .level (level),
        .full  (full_s),
        .empty (empty_s)
    );

    assign out_if.out_valid = ~empty_s;
    assign out_if.out_seq   = head_s.seq;
    assign out_if.out_i     = head_s.i;
    assign out_if.out_q     = head_s.q;
    assign out_if.out_mag   = head_s.mag;

    assign overflow = overflow_r;
    assign drop_cnt = drop_cnt_r;

    // Dump strobe delay and sequence tag; a dropped entry does not consume a tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dump_d_r <= 1'b0;
            seq_r    <= '0;
        end else begin
            dump_d_r <= dump & en;
            if (push_s && !drop_s) begin
                seq_r <= seq_r + {{(SEQ_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Sticky overflow and saturating drop count; a coincident drop outranks the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= '0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
            if (ovf_clr) begin
                drop_cnt_r <= {{(DROP_W-1){1'b0}}, 1'b1};
            end else if (!(&drop_cnt_r)) begin
                drop_cnt_r <= drop_cnt_r + {{(DROP_W-1){1'b0}}, 1'b1};
            end else begin
                drop_cnt_r <= drop_cnt_r;
            end
        end else if (ovf_clr) begin
            overflow_r <= 1'b0;
            drop_cnt_r <= '0;
        end else begin
            overflow_r <= overflow_r;
            drop_cnt_r <= drop_cnt_r;
        end
    end

endmodule

// File: tb/tb_dump_capture_fifo.sv
// Directed bench for dump_capture_fifo with a queue scoreboard of expected entries.
module tb_dump_capture_fifo;
    import gps_corr_pkg::*;

    localparam int DEPTH = 8;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        en      = 1'b0;
    logic        dump    = 1'b0;
    logic        ovf_clr = 1'b0;
    corr_sum_t   sum_i   = '0;
    corr_sum_t   sum_q   = '0;
    logic [3:0]  level;
    logic        overflow;
    logic [15:0] drop_cnt;

    dump_capture_fifo_if #(.SUM_W(SUM_W), .SEQ_W(SEQ_W)) bus ();

    dump_capture_fifo #(.SUM_W(SUM_W), .DEPTH(DEPTH), .SEQ_W(SEQ_W), .DROP_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .dump     (dump),
        .sum_i    (sum_i),
        .sum_q    (sum_q),
        .out_if   (bus),
        .level    (level),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_total = 0;
    dump_entry_t exp_q[$];
    corr_seq_t   m_seq   = '0;
    logic [15:0] m_drop  = '0;
    logic        m_ovf   = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic dump_entry_t mk(input corr_sum_t i, input corr_sum_t q);
        dump_entry_t e;
        int ai;
        int aq;
        ai = (i < 0) ? -int'(i) : int'(i);
        aq = (q < 0) ? -int'(q) : int'(q);
        e.seq = m_seq;
        e.i   = i;
        e.q   = q;
        e.mag = corr_mag_t'(ai + aq);
        return e;
    endfunction

    task automatic chk_head(input string tag);
        if (exp_q.size() == 0) begin
            chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        end else begin
            chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
            chk({tag, "_seq"},   64'(bus.out_seq),   64'(exp_q[0].seq));
            chk({tag, "_i"},     64'(bus.out_i),     64'(exp_q[0].i));
            chk({tag, "_q"},     64'(bus.out_q),     64'(exp_q[0].q));
            chk({tag, "_mag"},   64'(bus.out_mag),   64'(exp_q[0].mag));
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_level"}, 64'(level),    64'(exp_q.size()));
        chk({tag, "_ovf"},   64'(overflow), 64'(m_ovf));
        chk({tag, "_drop"},  64'(drop_cnt), 64'(m_drop));
    endtask

    // Strobe, then present sums in the push cycle with optional pop / clear / enable drop.
    task automatic do_dump(input corr_sum_t i, input corr_sum_t q, input logic pop,
                           input logic clr, input logic en_d, input logic en_m);
        logic dropped;
        en   = en_d;
        dump = 1'b1;
        tick();
        dump          = 1'b0;
        en            = en_m;
        sum_i         = i;
        sum_q         = q;
        bus.out_ready = pop;
        ovf_clr       = clr;
        if (exp_q.size() == 0) chk("pre_push_empty", 64'(bus.out_valid), 64'd0);
        else if (pop) chk_head("pop_head");
        tick();
        dropped = 1'b0;
        if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
        if (en_d) begin
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back(mk(i, q));
                m_seq++;
            end else begin
                dropped = 1'b1;
            end
        end
        if (dropped) begin
            m_ovf  = 1'b1;
            m_drop = clr ? 16'd1 : ((m_drop == 16'hffff) ? m_drop : m_drop + 16'd1);
        end else if (clr) begin
            m_ovf  = 1'b0;
            m_drop = 16'd0;
        end
        bus.out_ready = 1'b0;
        ovf_clr       = 1'b0;
        en            = 1'b1;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            if (exp_q.size() > 0) begin
                bus.out_ready = 1'b1;
                chk_head("drain");
                tick();
                void'(exp_q.pop_front());
            end
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        exp_q.delete();
        m_seq  = '0;
        m_drop = '0;
        m_ovf  = 1'b0;
        rst_n  = 1'b1;
        tick();
    endtask

    initial begin
        bus.out_ready = 1'b0;
        do_reset();
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_seq",   64'(bus.out_seq),   64'd0);
        chk("rst_i",     64'(bus.out_i),     64'd0);
        chk("rst_mag",   64'(bus.out_mag),   64'd0);
        chk_status("rst");

        // Single capture: +25 / -7.
        do_dump(corr_sum_t'(25), corr_sum_t'(-7), 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t1_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_seq",   64'(bus.out_seq),   64'd0);
        chk("t1_mag",   64'(bus.out_mag),   64'd32);
        chk_head("t1");
        drain(1);

        // Nine dumps into eight slots.
        do_reset();
        for (int k = 0; k < 9; k++)
            do_dump(corr_sum_t'($urandom), corr_sum_t'($urandom), 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t2_level", 64'(level),    64'd8);
        chk("t2_ovf",   64'(overflow), 64'd1);
        chk("t2_drop",  64'(drop_cnt), 64'd1);
        chk("t2_head",  64'(bus.out_seq), 64'd0);

        // Full with simultaneous pop: no drop, new tail takes seq 8.
        do_dump(corr_sum_t'(-1234), corr_sum_t'(4321), 1'b1, 1'b0, 1'b1, 1'b1);
        chk("t3_level", 64'(level),    64'd8);
        chk("t3_drop",  64'(drop_cnt), 64'd1);
        chk_status("t3");
        drain(8);

        // Drop coincident with ovf_clr, then clear alone.
        for (int k = 0; k < 9; k++)
            do_dump(corr_sum_t'($urandom), corr_sum_t'($urandom), 1'b0, 1'b0, 1'b1, 1'b1);
        chk_status("t5_pre");
        do_dump(corr_sum_t'(3), corr_sum_t'(3), 1'b0, 1'b1, 1'b1, 1'b1);
        chk("t5_ovf",  64'(overflow), 64'd1);
        chk("t5_drop", 64'(drop_cnt), 64'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        m_ovf   = 1'b0;
        m_drop  = 16'd0;
        chk("t5_clr_ovf",  64'(overflow), 64'd0);
        chk("t5_clr_drop", 64'(drop_cnt), 64'd0);
        drain(8);

        // Most-negative sums and sequence wrap.
        do_dump(corr_sum_t'(-65536), corr_sum_t'(-65536), 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t4_mag", 64'(bus.out_mag), 64'd131072);
        chk_head("t4");
        for (int k = 0; k < 256; k++)
            do_dump(corr_sum_t'($urandom), corr_sum_t'($urandom), 1'b1, 1'b0, 1'b1, 1'b1);
        chk_head("t4_wrap");
        chk_status("t4");
        drain(1);

        // Dump held two cycles gives two consecutive pushes.
        en   = 1'b1;
        dump = 1'b1;
        tick();
        sum_i = corr_sum_t'(100);
        sum_q = corr_sum_t'(-200);
        tick();
        exp_q.push_back(mk(corr_sum_t'(100), corr_sum_t'(-200)));
        m_seq++;
        sum_i = corr_sum_t'(-300);
        sum_q = corr_sum_t'(400);
        dump  = 1'b0;
        tick();
        exp_q.push_back(mk(corr_sum_t'(-300), corr_sum_t'(400)));
        m_seq++;
        chk_status("burst");
        drain(2);

        // Asynchronous reset with five entries held.
        for (int k = 0; k < 5; k++)
            do_dump(corr_sum_t'($urandom), corr_sum_t'($urandom), 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t6_pre_level", 64'(level), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_level", 64'(level),         64'd0);
        chk("t6_rst_valid", 64'(bus.out_valid), 64'd0);
        exp_q.delete();
        m_seq  = '0;
        m_drop = '0;
        m_ovf  = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        do_dump(corr_sum_t'(7), corr_sum_t'(7), 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t6_seq", 64'(bus.out_seq), 64'd0);
        chk_head("t6");
        drain(1);

        // Disabled dump is ignored; a pending one still lands after en falls.
        do_dump(corr_sum_t'(1), corr_sum_t'(1), 1'b0, 1'b0, 1'b0, 1'b0);
        chk_status("t6_en0");
        do_dump(corr_sum_t'(5), corr_sum_t'(-5), 1'b0, 1'b0, 1'b1, 1'b0);
        chk_status("t6_pend");
        chk_head("t6_pend");
        drain(1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
